// File: rtl/proc_hier_top.sv
// Commit-trace qualification and statistics counters for the 16-bit pipelined processor.
// Define CACHE_STATS_EN to build the four cache event counters; otherwise they read as 0.
module proc_hier_top #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ftch_post_pc,
  input  logic [15:0]      ftch_instruction,
  input  logic             ftch_halt_pc,
  input  logic [4:0]       wb_opcode,
  input  logic             wb_regwrite,
  input  logic             wb_fwd_stall,
  input  logic [2:0]       wb_write_reg_sel,
  input  logic [15:0]      wb_write_data,
  input  logic             mem_fwd_stall,
  input  logic             mem_dmem_en,
  input  logic             mem_dmem_write,
  input  logic [15:0]      mem_out,
  input  logic [15:0]      mem_read_data2,
  input  logic [15:0]      mem_dataout,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic [15:0]      pc,
  output logic [15:0]      inst,
  output logic             reg_write,
  output logic [2:0]       write_register,
  output logic [15:0]      write_data,
  output logic             mem_read,
  output logic             mem_write,
  output logic [15:0]      mem_address,
  output logic [15:0]      mem_data_in,
  output logic [15:0]      mem_data_out,
  output logic             halt,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] icache_hit_count,
  output logic [CNT_W-1:0] icache_req_count,
  output logic [CNT_W-1:0] dcache_hit_count,
  output logic [CNT_W-1:0] dcache_req_count
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             nop;
  logic             run;
  logic             commit;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] inst_q, inst_d;

  // Memory-stage qualification deliberately uses the writeback opcode for NOP detection.
  assign nop       = (wb_opcode == 5'b00001);
  assign reg_write = wb_regwrite & ~nop & ~wb_fwd_stall;
  assign mem_read  = mem_dmem_en & ~mem_dmem_write & ~nop & ~mem_fwd_stall;
  assign mem_write = mem_dmem_write & ~nop & ~mem_fwd_stall;
  assign halt      = ftch_halt_pc & ~halted_q;
  assign run       = ~halted_q;
  assign commit    = halt | reg_write | mem_write;

  assign pc             = ftch_post_pc;
  assign inst           = ftch_instruction;
  assign write_register = wb_write_reg_sel;
  assign write_data     = wb_write_data;
  assign mem_address    = mem_out;
  assign mem_data_in    = mem_read_data2;
  assign mem_data_out   = mem_dataout;
  assign halted         = halted_q;
  assign cycle_count    = cycle_q;
  assign inst_count     = inst_q;

  always_comb begin
    halted_d = halted_q | halt;
    cycle_d  = cycle_q;
    inst_d   = inst_q;
    if (run) begin
      cycle_d = cycle_q + CntOne;
      if (commit) inst_d = inst_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
      cycle_q  <= '0;
      inst_q   <= '0;
    end else begin
      halted_q <= halted_d;
      cycle_q  <= cycle_d;
      inst_q   <= inst_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] ic_hit_q, ic_hit_d;
  logic [CNT_W-1:0] ic_req_q, ic_req_d;
  logic [CNT_W-1:0] dc_hit_q, dc_hit_d;
  logic [CNT_W-1:0] dc_req_q, dc_req_d;

  always_comb begin
    ic_hit_d = ic_hit_q;
    ic_req_d = ic_req_q;
    dc_hit_d = dc_hit_q;
    dc_req_d = dc_req_q;
    if (run) begin
      if (icache_hit) ic_hit_d = ic_hit_q + CntOne;
      if (icache_req) ic_req_d = ic_req_q + CntOne;
      if (dcache_hit) dc_hit_d = dc_hit_q + CntOne;
      if (dcache_req) dc_req_d = dc_req_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_hit_q <= '0;
      ic_req_q <= '0;
      dc_hit_q <= '0;
      dc_req_q <= '0;
    end else begin
      ic_hit_q <= ic_hit_d;
      ic_req_q <= ic_req_d;
      dc_hit_q <= dc_hit_d;
      dc_req_q <= dc_req_d;
    end
  end

  assign icache_hit_count = ic_hit_q;
  assign icache_req_count = ic_req_q;
  assign dcache_hit_count = dc_hit_q;
  assign dcache_req_count = dc_req_q;
`else
  logic unused_cache_strobes;
  assign unused_cache_strobes = ^{icache_req, icache_hit, dcache_req, dcache_hit};

  assign icache_hit_count = '0;
  assign icache_req_count = '0;
  assign dcache_hit_count = '0;
  assign dcache_req_count = '0;
`endif

endmodule

// File: tb/tb_proc_hier_top.sv
// Scoreboard bench for proc_hier_top: stimulus pushes model predictions, a negedge monitor
// pops and compares them against the DUT.
module tb_proc_hier_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ftch_post_pc, ftch_instruction;
  logic        ftch_halt_pc;
  logic [4:0]  wb_opcode;
  logic        wb_regwrite, wb_fwd_stall;
  logic [2:0]  wb_write_reg_sel;
  logic [15:0] wb_write_data;
  logic        mem_fwd_stall, mem_dmem_en, mem_dmem_write;
  logic [15:0] mem_out, mem_read_data2, mem_dataout;
  logic        icache_req, icache_hit, dcache_req, dcache_hit;

  logic [15:0] pc, inst, write_data, mem_address, mem_data_in, mem_data_out;
  logic        reg_write, mem_read, mem_write, halt, halted;
  logic [2:0]  write_register;
  logic [31:0] cycle_count, inst_count;
  logic [31:0] icache_hit_count, icache_req_count, dcache_hit_count, dcache_req_count;

  proc_hier_top #(.CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .ftch_post_pc     (ftch_post_pc),
    .ftch_instruction (ftch_instruction),
    .ftch_halt_pc     (ftch_halt_pc),
    .wb_opcode        (wb_opcode),
    .wb_regwrite      (wb_regwrite),
    .wb_fwd_stall     (wb_fwd_stall),
    .wb_write_reg_sel (wb_write_reg_sel),
    .wb_write_data    (wb_write_data),
    .mem_fwd_stall    (mem_fwd_stall),
    .mem_dmem_en      (mem_dmem_en),
    .mem_dmem_write   (mem_dmem_write),
    .mem_out          (mem_out),
    .mem_read_data2   (mem_read_data2),
    .mem_dataout      (mem_dataout),
    .icache_req       (icache_req),
    .icache_hit       (icache_hit),
    .dcache_req       (dcache_req),
    .dcache_hit       (dcache_hit),
    .pc               (pc),
    .inst             (inst),
    .reg_write        (reg_write),
    .write_register   (write_register),
    .write_data       (write_data),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out),
    .halt             (halt),
    .halted           (halted),
    .cycle_count      (cycle_count),
    .inst_count       (inst_count),
    .icache_hit_count (icache_hit_count),
    .icache_req_count (icache_req_count),
    .dcache_hit_count (dcache_hit_count),
    .dcache_req_count (dcache_req_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc, inst, wdata, maddr, mdin, mdout;
    logic [2:0]  wreg;
    logic        rw, mr, mw, halt, halted;
    logic [31:0] cyc, ins, ich, icr, dch, dcr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: counts of events seen since the last reset.
  logic [31:0] m_cyc, m_ins, m_ich, m_icr, m_dch, m_dcr;
  bit          m_halted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  // Predict the DUT outputs for the inputs now applied, then advance the model by one edge.
  task automatic push_exp();
    exp_t x;
    bit   nop, rw, mw, hl, in_rst;
    in_rst = (rst == 1'b0);
    if (in_rst) begin
      m_cyc = 0; m_ins = 0; m_ich = 0; m_icr = 0; m_dch = 0; m_dcr = 0;
      m_halted = 0;
    end
    nop = (wb_opcode == 5'd1);
    rw  = wb_regwrite && !nop && !wb_fwd_stall;
    mw  = mem_dmem_write && !nop && !mem_fwd_stall;
    hl  = ftch_halt_pc && !m_halted;
    x.pc = ftch_post_pc; x.inst = ftch_instruction;
    x.wdata = wb_write_data; x.wreg = wb_write_reg_sel;
    x.maddr = mem_out; x.mdin = mem_read_data2; x.mdout = mem_dataout;
    x.rw = rw; x.mw = mw;
    x.mr = mem_dmem_en && !mem_dmem_write && !nop && !mem_fwd_stall;
    x.halt = hl; x.halted = m_halted;
    x.cyc = m_cyc; x.ins = m_ins;
    x.ich = m_ich; x.icr = m_icr; x.dch = m_dch; x.dcr = m_dcr;
    exp_q.push_back(x);
    if (!in_rst && !m_halted) begin
      m_cyc++;
      if (hl || rw || mw) m_ins++;
`ifdef CACHE_STATS_EN
      if (icache_hit) m_ich++;
      if (icache_req) m_icr++;
      if (dcache_hit) m_dch++;
      if (dcache_req) m_dcr++;
`endif
      if (hl) m_halted = 1;
    end
  endtask

  task automatic idle_inputs();
    ftch_post_pc = 16'h0; ftch_instruction = 16'h0; ftch_halt_pc = 0;
    wb_opcode = 5'b00010; wb_regwrite = 0; wb_fwd_stall = 0;
    wb_write_reg_sel = 0; wb_write_data = 0;
    mem_fwd_stall = 0; mem_dmem_en = 0; mem_dmem_write = 0;
    mem_out = 0; mem_read_data2 = 0; mem_dataout = 0;
    icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic random_inputs();
    ftch_post_pc     = 16'($urandom);
    ftch_instruction = 16'($urandom);
    ftch_halt_pc     = ($urandom_range(0, 39) == 0);
    wb_opcode        = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'($urandom);
    wb_regwrite      = 1'($urandom);
    wb_fwd_stall     = ($urandom_range(0, 4) == 0);
    wb_write_reg_sel = 3'($urandom);
    wb_write_data    = 16'($urandom);
    mem_fwd_stall    = ($urandom_range(0, 4) == 0);
    mem_dmem_en      = 1'($urandom);
    mem_dmem_write   = 1'($urandom);
    mem_out          = 16'($urandom);
    mem_read_data2   = 16'($urandom);
    mem_dataout      = 16'($urandom);
    icache_req       = 1'($urandom);
    icache_hit       = 1'($urandom);
    dcache_req       = 1'($urandom);
    dcache_hit       = 1'($urandom);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc", 32'(pc), 32'(e.pc));
      check("inst", 32'(inst), 32'(e.inst));
      check("reg_write", 32'(reg_write), 32'(e.rw));
      check("write_register", 32'(write_register), 32'(e.wreg));
      check("write_data", 32'(write_data), 32'(e.wdata));
      check("mem_read", 32'(mem_read), 32'(e.mr));
      check("mem_write", 32'(mem_write), 32'(e.mw));
      check("mem_address", 32'(mem_address), 32'(e.maddr));
      check("mem_data_in", 32'(mem_data_in), 32'(e.mdin));
      check("mem_data_out", 32'(mem_data_out), 32'(e.mdout));
      check("halt", 32'(halt), 32'(e.halt));
      check("halted", 32'(halted), 32'(e.halted));
      check("cycle_count", cycle_count, e.cyc);
      check("inst_count", inst_count, e.ins);
      check("icache_hit_count", icache_hit_count, e.ich);
      check("icache_req_count", icache_req_count, e.icr);
      check("dcache_hit_count", dcache_hit_count, e.dch);
      check("dcache_req_count", dcache_req_count, e.dcr);
    end
  end

  initial begin
    m_cyc = 0; m_ins = 0; m_ich = 0; m_icr = 0; m_dch = 0; m_dcr = 0; m_halted = 0;
    rst = 0;
    idle_inputs();

    // Reset held with every strobe active.
    next_cycle();
    rst = 0; ftch_halt_pc = 1; wb_regwrite = 1; mem_dmem_write = 1;
    icache_req = 1; icache_hit = 1; dcache_req = 1; dcache_hit = 1;
    push_exp();
    next_cycle(); push_exp();
    next_cycle(); rst = 1; idle_inputs(); push_exp();
    repeat (3) begin next_cycle(); push_exp(); end

    // Register write.
    next_cycle();
    wb_regwrite = 1; wb_opcode = 5'b00010; wb_write_reg_sel = 3; wb_write_data = 16'h1234;
    push_exp();
    next_cycle(); idle_inputs(); push_exp();

    // NOP gating, then memory-stall gating.
    next_cycle();
    wb_opcode = 5'b00001; wb_regwrite = 1; mem_dmem_write = 1; push_exp();
    next_cycle();
    wb_opcode = 5'b00011; mem_fwd_stall = 1; push_exp();
    next_cycle(); idle_inputs(); push_exp();

    // Load.
    next_cycle();
    mem_dmem_en = 1; mem_out = 16'h0040; mem_dataout = 16'hBEEF; push_exp();

    // Simultaneous register write and store.
    next_cycle();
    idle_inputs(); wb_regwrite = 1; mem_dmem_en = 1; mem_dmem_write = 1; push_exp();

    // Cache: 4 icache requests, 3 hits.
    for (int i = 0; i < 4; i++) begin
      next_cycle(); idle_inputs(); icache_req = 1; icache_hit = (i != 2); push_exp();
    end

    // Halt after 10 cycles out of reset, then more events.
    next_cycle(); rst = 0; idle_inputs(); push_exp();
    next_cycle(); rst = 1; push_exp();
    repeat (9) begin next_cycle(); push_exp(); end
    next_cycle(); ftch_halt_pc = 1; push_exp();
    repeat (4) begin
      next_cycle(); random_inputs(); ftch_halt_pc = 1; push_exp();
    end

    // Randomised run with occasional resets.
    next_cycle(); rst = 0; idle_inputs(); push_exp();
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      random_inputs();
      rst = ($urandom_range(0, 49) != 0);
      push_exp();
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_hier_top.md
# proc_hier_top

Top-level observation and statistics block of the 16-bit pipelined processor hierarchy. Sits beside the core: takes fetch, memory-stage and writeback-stage signals and produces architecturally qualified per-cycle commit trace signals (register write, load, store, halt). Keeps cycle, instruction and cache statistics counters for the simulation log and trace.

## Interface
Parameters:
- CNT_W, 32: width of all statistics counters.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ftch_post_pc  in  16  PC of the fetched instruction.
- ftch_instruction  in  16  fetched instruction word.
- ftch_halt_pc  in  1  halt instruction reached the commit point.
- wb_opcode  in  5  writeback-stage opcode; 5'b00001 is NOP.
- wb_regwrite  in  1  writeback register-write enable.
- wb_fwd_stall  in  1  writeback slot is a forwarding-stall bubble (reg1 or reg2 stall, pre-ORed).
- wb_write_reg_sel  in  3  destination register.
- wb_write_data  in  16  writeback data.
- mem_fwd_stall  in  1  memory slot is a forwarding-stall bubble.
- mem_dmem_en  in  1  data-memory enable.
- mem_dmem_write  in  1  data-memory write.
- mem_out  in  16  data-memory address.
- mem_read_data2  in  16  store data.
- mem_dataout  in  16  load data.
- icache_req, icache_hit, dcache_req, dcache_hit  in  1 each  cache event strobes.
- pc, inst  out  16  copies of ftch_post_pc, ftch_instruction.
- reg_write  out  1  qualified register write.
- write_register  out  3; write_data  out  16  pass-through.
- mem_read, mem_write  out  1  qualified load/store.
- mem_address, mem_data_in, mem_data_out  out  16  pass-through of mem_out, mem_read_data2, mem_dataout.
- halt  out  1  copy of ftch_halt_pc, gated by halted.
- halted  out  1  sticky halt flag.
- cycle_count, inst_count, icache_hit_count, icache_req_count, dcache_hit_count, dcache_req_count  out  CNT_W  statistics.

## Operation
- nop = (wb_opcode == 5'b00001).
- reg_write = wb_regwrite & ~nop & ~wb_fwd_stall.
- mem_read = mem_dmem_en & ~mem_dmem_write & ~nop & ~mem_fwd_stall.
- mem_write = mem_dmem_write & ~nop & ~mem_fwd_stall.
- NOP gating for the memory outputs uses the writeback opcode, intentionally.
- halt = ftch_halt_pc & ~halted.
- Commit event = halt | reg_write | mem_write. inst_count +1 per commit-event cycle (a cycle counts once even if several strobes are set).
- Cache counters +1 per cycle their strobe is high.
- cycle_count +1 every cycle out of reset.
- halted sets on the first cycle with halt = 1 and stays set until reset. While halted, all counters freeze. The halt cycle itself is counted in every counter.
- Counters wrap modulo 2^CNT_W.

## Timing
- All trace outputs are combinational, zero latency.
- Counters and halted update on the rising clk edge. Each value reflects events of the cycles before that edge.
- rst low asserts asynchronously: all counters = 0, halted = 0. Trace outputs stay combinational during reset.
- A reset mid-run clears all statistics immediately. Counting resumes on the first edge after rst rises.
- Simultaneous reg_write and mem_write: inst_count +1, not +2.

## Configuration
- CACHE_STATS_EN defined: the four cache counters operate as specified.
- Not defined: cache strobe inputs are ignored and the four cache counters are constant 0. Counter flops are not synthesized.

## Test plan
- Reset: hold rst low with all strobes high -> every counter 0 and halted 0; release rst and run 3 edges -> cycle_count = 3.
- Register write with wb_regwrite = 1, wb_opcode = 5'b00010, wb_write_reg_sel = 3, wb_write_data = 16'h1234 -> reg_write = 1, write_register = 3, write_data = 16'h1234; inst_count +1 next edge.
- NOP and stall gating: wb_opcode = 5'b00001 with wb_regwrite = 1 and mem_dmem_write = 1 -> reg_write = 0, mem_write = 0, inst_count unchanged. Repeat with a valid opcode and mem_fwd_stall = 1 -> mem_write = 0, reg_write unaffected.
- Load: mem_dmem_en = 1, mem_dmem_write = 0, mem_out = 16'h0040, mem_dataout = 16'hBEEF -> mem_read = 1, mem_address = 16'h0040, mem_data_out = 16'hBEEF; inst_count unchanged.
- Halt: pulse ftch_halt_pc after 10 cycles, then keep driving events -> halt = 1 for one cycle, halted = 1, cycle_count frozen at 11, further events not counted.
- Cache stats: 4 cycles of icache_req with 3 of them also icache_hit -> icache_req_count = 4, icache_hit_count = 3 with CACHE_STATS_EN defined; both 0 without it.
